// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decoder control, operands and fields in;
// registered execute-side word, hazard stall and branch redirect out.
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          WB_en;
   logic          isImmediate;
   logic          memRead;
   logic          memWrite;
   logic [3:0]    executeCMD;
   logic [1:0]    BR;
   logic          twoSoursec;
   logic [DW-1:0] PC_in;
   logic [DW-1:0] val1;
   logic [DW-1:0] val2;
   logic [15:0]   imm;
   logic [RW-1:0] src1;
   logic [RW-1:0] src2;
   logic [RW-1:0] dest;
   logic          mem_WB_en;
   logic [RW-1:0] mem_dest;
   logic          freeze;

   logic          hazard_stall;
   logic          branch_taken;
   logic [DW-1:0] branch_addr;
   logic          ex_WB_en;
   logic          ex_memRead;
   logic          ex_memWrite;
   logic [3:0]    ex_executeCMD;
   logic [DW-1:0] ex_val1;
   logic [DW-1:0] ex_val2;
   logic [DW-1:0] ex_stVal;
   logic [RW-1:0] ex_src1;
   logic [RW-1:0] ex_src2;
   logic [RW-1:0] ex_dest;
   logic [DW-1:0] ex_PC;

   modport master (
      output WB_en, isImmediate, memRead, memWrite,
      output executeCMD, BR, twoSoursec,
      output PC_in, val1, val2, imm,
      output src1, src2, dest,
      output mem_WB_en, mem_dest, freeze,
      input  hazard_stall, branch_taken, branch_addr,
      input  ex_WB_en, ex_memRead, ex_memWrite,
      input  ex_executeCMD,
      input  ex_val1, ex_val2, ex_stVal,
      input  ex_src1, ex_src2, ex_dest, ex_PC
   );

   modport slave (
      input  WB_en, isImmediate, memRead, memWrite,
      input  executeCMD, BR, twoSoursec,
      input  PC_in, val1, val2, imm,
      input  src1, src2, dest,
      input  mem_WB_en, mem_dest, freeze,
      output hazard_stall, branch_taken, branch_addr,
      output ex_WB_en, ex_memRead, ex_memWrite,
      output ex_executeCMD,
      output ex_val1, ex_val2, ex_stVal,
      output ex_src1, ex_src2, ex_dest, ex_PC
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall and decode-stage branch resolve.
// Define ID_EX_FWD_EN when execute forwards; then only load-use stalls non-branches.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);

   typedef struct packed {
      logic       wb_en;
      logic       mem_read;
      logic       mem_write;
      logic [3:0] cmd;
   } ctrl_t;

   typedef struct packed {
      logic [DW-1:0] val1;
      logic [DW-1:0] val2;
      logic [DW-1:0] st_val;
      logic [RW-1:0] src1;
      logic [RW-1:0] src2;
      logic [RW-1:0] dest;
      logic [DW-1:0] pc;
   } data_t;

   ctrl_t ctrl_q;
   data_t data_q;
   ctrl_t ctrl_d;
   data_t data_d;

   logic [DW-1:0] imm_sext;
   logic          use1;
   logic          use2;
   logic          ex_match;
   logic          mem_match;
   logic          dep_ex;
   logic          dep_mem;
   logic          is_cond_br;
   logic          load_use;
   logic          br_haz;
   logic          nb_haz;
   logic          stall;
   logic          cond;

   assign imm_sext = {{(DW-16){bus.imm[15]}}, bus.imm};

   assign use1 = bus.src1 != '0;
   assign use2 = bus.twoSoursec & (bus.src2 != '0);

   assign ex_match =
      (use1 & (bus.src1 == ctrl_dest_ex())) |
      (use2 & (bus.src2 == ctrl_dest_ex()));

   assign mem_match =
      (use1 & (bus.src1 == bus.mem_dest)) |
      (use2 & (bus.src2 == bus.mem_dest));

   function automatic logic [RW-1:0] ctrl_dest_ex();
      return data_q.dest;
   endfunction

   assign dep_ex     = ctrl_q.wb_en & ex_match;
   assign dep_mem    = bus.mem_WB_en & mem_match;
   assign is_cond_br = (bus.BR == 2'b01) | (bus.BR == 2'b10);
   assign load_use   = ctrl_q.mem_read & ex_match;
   assign br_haz     = is_cond_br & (dep_ex | dep_mem);

`ifdef ID_EX_FWD_EN
   assign nb_haz = 1'b0;
`else
   // Without forwarding every consumer waits until its producer reaches WB.
   assign nb_haz = !is_cond_br & (dep_ex | dep_mem);
`endif

   assign stall = (load_use | br_haz | nb_haz) & !bus.freeze & !rst;

   always_comb begin
      cond = 1'b0;
      unique case (bus.BR)
         2'b01:   cond = bus.val1 == '0;
         2'b10:   cond = bus.val1 != bus.val2;
         2'b11:   cond = 1'b1;
         default: cond = 1'b0;
      endcase
   end

   assign bus.hazard_stall = stall;
   assign bus.branch_taken = cond & !stall & !bus.freeze & !rst;
   assign bus.branch_addr  = bus.PC_in + (imm_sext << 2);

   always_comb begin
      ctrl_d.wb_en     = bus.WB_en;
      ctrl_d.mem_read  = bus.memRead;
      ctrl_d.mem_write = bus.memWrite;
      ctrl_d.cmd       = bus.executeCMD;
      data_d.val1      = bus.val1;
      data_d.val2      = bus.isImmediate ? imm_sext : bus.val2;
      data_d.st_val    = bus.val2;
      data_d.src1      = bus.src1;
      data_d.src2      = bus.src2;
      data_d.dest      = bus.dest;
      data_d.pc        = bus.PC_in;
   end

   // A bubble only kills control; data/fields keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else if (bus.freeze) begin
         ctrl_q <= ctrl_q;
         data_q <= data_q;
      end else if (stall) begin
         ctrl_q <= '0;
         data_q <= data_q;
      end else begin
         ctrl_q <= ctrl_d;
         data_q <= data_d;
      end
   end

   assign bus.ex_WB_en      = ctrl_q.wb_en;
   assign bus.ex_memRead    = ctrl_q.mem_read;
   assign bus.ex_memWrite   = ctrl_q.mem_write;
   assign bus.ex_executeCMD = ctrl_q.cmd;
   assign bus.ex_val1       = data_q.val1;
   assign bus.ex_val2       = data_q.val2;
   assign bus.ex_stVal      = data_q.st_val;
   assign bus.ex_src1       = data_q.src1;
   assign bus.ex_src2       = data_q.src2;
   assign bus.ex_dest       = data_q.dest;
   assign bus.ex_PC         = data_q.pc;

endmodule
